// File: rtl/ipg_pause_pkg.sv
// Shared XGMII constants and types for the PHY-level pause ordered-set path (TX insert, RX decode).
package ipg_pause_pkg;

    localparam logic [7:0]  XGMII_IDLE   = 8'h07;
    localparam logic [7:0]  XGMII_SEQ_OS = 8'h9C;
    localparam logic [7:0]  PAUSE_MAGIC  = 8'hEE;
    localparam logic [63:0] IDLE_WORD    = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_TXC     = 8'hFF;
    localparam logic [7:0]  PAUSE_TXC    = 8'hF1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        GAP
    } pause_state_e;

    typedef logic [1:0] pause_code_t;
    typedef logic [3:0] pause_seq_t;

    // Lane 0 is bits [7:0]. The upper four lanes stay idle control characters.
    function automatic logic [63:0] pause_word(input pause_code_t code, input pause_seq_t seq);
        return {{4{XGMII_IDLE}}, {4'b0000, seq}, {6'b000000, code}, PAUSE_MAGIC, XGMII_SEQ_OS};
    endfunction

endpackage

// File: rtl/xgmii_idle_detect.sv
// Combinational test for a whole XGMII idle word (all lanes control, all lanes 8'h07).
module xgmii_idle_detect
    import ipg_pause_pkg::*;
(
    input  logic [63:0] xgmii_d,
    input  logic [7:0]  xgmii_c,
    output logic        is_idle
);

    assign is_idle = (xgmii_c == IDLE_TXC) && (xgmii_d == IDLE_WORD);

endmodule

// File: rtl/ipg_pause_tx_inserter.sv
// Replaces whole XGMII idle words with pause ordered-sets, REPEAT_COUNT copies per request.
// Optional build macro IPG_PAUSE_STATS_EN adds saturating stat_sent / stat_timeout counters.
//
// state | meaning
// IDLE  | ready for a request
// ARMED | waiting for an idle word to carry the next copy (bounded by MAX_WAIT)
// GAP   | enforcing the minimum spacing between copies
module ipg_pause_tx_inserter
    import ipg_pause_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int REPEAT_COUNT = 3,
    parameter int REPEAT_GAP   = 4,
    parameter int MAX_WAIT     = 1024
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [DATA_WIDTH-1:0] xgmii_txd_in,
    input  logic [CTRL_WIDTH-1:0] xgmii_txc_in,
    output logic [DATA_WIDTH-1:0] xgmii_txd_out,
    output logic [CTRL_WIDTH-1:0] xgmii_txc_out,
    input  logic                  pause_req_valid,
    input  logic [1:0]            pause_req_code,
    output logic                  pause_req_ready,
    output logic                  pause_sent,
    output logic                  pause_timeout,
    output logic                  pause_busy
`ifdef IPG_PAUSE_STATS_EN
    ,
    output logic [31:0]           stat_sent,
    output logic [31:0]           stat_timeout
`endif
);

    localparam logic [3:0]  REPEAT_LAST = 4'(REPEAT_COUNT);
    localparam logic [7:0]  GAP_LAST    = 8'(REPEAT_GAP - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(MAX_WAIT - 1);
    // With a spacing of one cycle copies may go out back to back, so GAP is never entered.
    localparam bit          GAP_SKIP    = (REPEAT_GAP <= 1);

    pause_state_e          state_q, state_d;
    pause_code_t           code_q, code_d;
    pause_seq_t            seq_q, seq_d;
    logic [3:0]            copies_q, copies_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic [CTRL_WIDTH-1:0] txc_q, txc_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  sent_q, sent_d;
    logic                  timeout_q, timeout_d;
    logic                  in_idle;

    xgmii_idle_detect u_idle_detect (
        .xgmii_d (xgmii_txd_in),
        .xgmii_c (xgmii_txc_in),
        .is_idle (in_idle)
    );

    // Next-state, counters and the output word for the single register stage.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        seq_d      = seq_q;
        copies_d   = copies_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        txd_d      = xgmii_txd_in;
        txc_d      = xgmii_txc_in;
        sent_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pause_req_valid && ready_q) begin
                    code_d     = pause_req_code;
                    seq_d      = seq_q + 4'd1;
                    copies_d   = 4'd0;
                    wait_cnt_d = 16'd0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (in_idle) begin
                    txd_d    = pause_word(code_q, seq_q);
                    txc_d    = PAUSE_TXC;
                    copies_d = copies_q + 4'd1;
                    if (copies_d == REPEAT_LAST) begin
                        sent_d  = 1'b1;
                        state_d = IDLE;
                    end else if (GAP_SKIP) begin
                        wait_cnt_d = 16'd0;
                    end else begin
                        gap_cnt_d = 8'd0;
                        state_d   = GAP;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            GAP: begin
                // Compare the incremented count so the next copy is REPEAT_GAP cycles after this one.
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_d == GAP_LAST) begin
                    wait_cnt_d = 16'd0;
                    state_d    = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset drops any request and forces an idle word.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q    <= IDLE;
            code_q     <= 2'b00;
            seq_q      <= 4'd0;
            copies_q   <= 4'd0;
            wait_cnt_q <= 16'd0;
            gap_cnt_q  <= 8'd0;
            txd_q      <= IDLE_WORD;
            txc_q      <= IDLE_TXC;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            seq_q      <= seq_d;
            copies_q   <= copies_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            timeout_q  <= timeout_d;
        end
    end

    assign xgmii_txd_out   = txd_q;
    assign xgmii_txc_out   = txc_q;
    assign pause_req_ready = ready_q;
    assign pause_busy      = busy_q;
    assign pause_sent      = sent_q;
    assign pause_timeout   = timeout_q;

`ifdef IPG_PAUSE_STATS_EN
    logic [31:0] stat_sent_q, stat_sent_d;
    logic [31:0] stat_timeout_q, stat_timeout_d;

    // Saturating event counts, advanced on the same cycle the pulse is registered.
    always_comb begin
        stat_sent_d    = stat_sent_q;
        stat_timeout_d = stat_timeout_q;
        if (sent_d && (stat_sent_q != 32'hFFFF_FFFF)) begin
            stat_sent_d = stat_sent_q + 32'd1;
        end
        if (timeout_d && (stat_timeout_q != 32'hFFFF_FFFF)) begin
            stat_timeout_d = stat_timeout_q + 32'd1;
        end
    end

    // Statistics registers, cleared with the rest of the block.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            stat_sent_q    <= 32'd0;
            stat_timeout_q <= 32'd0;
        end else begin
            stat_sent_q    <= stat_sent_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_sent    = stat_sent_q;
    assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_ipg_pause_tx_inserter.sv
// Self-checking bench: a cycle model pushes the expected output word and flags into a scoreboard
// when each input word is driven; they are popped and compared one cycle later.
module tb_ipg_pause_tx_inserter;

    localparam int REP  = 3;
    localparam int RGAP = 4;
    localparam int MAXW = 16;
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [63:0] xgmii_txd_in = IDLE_W;
    logic [7:0]  xgmii_txc_in = 8'hFF;
    logic [63:0] xgmii_txd_out;
    logic [7:0]  xgmii_txc_out;
    logic        pause_req_valid = 1'b0;
    logic [1:0]  pause_req_code = 2'b00;
    logic        pause_req_ready, pause_sent, pause_timeout, pause_busy;
`ifdef IPG_PAUSE_STATS_EN
    logic [31:0] stat_sent, stat_timeout;
`endif

    always #5 tx_clk = ~tx_clk;

    ipg_pause_tx_inserter #(
        .DATA_WIDTH   (64),
        .CTRL_WIDTH   (8),
        .REPEAT_COUNT (REP),
        .REPEAT_GAP   (RGAP),
        .MAX_WAIT     (MAXW)
    ) dut (
        .tx_clk          (tx_clk),
        .tx_rst          (tx_rst),
        .xgmii_txd_in    (xgmii_txd_in),
        .xgmii_txc_in    (xgmii_txc_in),
        .xgmii_txd_out   (xgmii_txd_out),
        .xgmii_txc_out   (xgmii_txc_out),
        .pause_req_valid (pause_req_valid),
        .pause_req_code  (pause_req_code),
        .pause_req_ready (pause_req_ready),
        .pause_sent      (pause_sent),
        .pause_timeout   (pause_timeout),
        .pause_busy      (pause_busy)
`ifdef IPG_PAUSE_STATS_EN
        ,
        .stat_sent       (stat_sent),
        .stat_timeout    (stat_timeout)
`endif
    );

    // flags = {ready, busy, sent, timeout}
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // model state
    logic       m_active = 1'b0;
    logic       m_ready  = 1'b0;
    logic [3:0] m_seq    = 4'd0;
    logic [1:0] m_code   = 2'b00;
    int         m_copies = 0;
    int         m_next_ok = 0;
    int         m_deadline = 0;
    int         m_acc_cyc = 0;

    // observation
    int         cyc = 0;
    int         pause_cnt = 0, sent_cnt = 0, to_cnt = 0, to_cyc = 0;
    logic [3:0] last_seq = 4'd0;
    logic [1:0] last_code = 2'b00;
    int         pause_cyc[$];
    logic [3:0] seqs[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic [63:0] d, input logic [7:0] c,
                              input logic v, input logic [1:0] code, output exp_t e);
        logic idle_in, sent, to;
        e.d = d;
        e.c = c;
        sent = 1'b0;
        to = 1'b0;
        if (rst) begin
            e.d = IDLE_W;
            e.c = 8'hFF;
            m_active = 1'b0;
            m_ready = 1'b0;
            m_seq = 4'd0;
            m_copies = 0;
            e.flags = 4'b0000;
        end else begin
            idle_in = (c == 8'hFF) && (d == IDLE_W);
            if (m_active) begin
                if (cyc >= m_next_ok) begin
                    if (idle_in) begin
                        e.d = {32'h0707_0707, 4'h0, m_seq, 6'h00, m_code, 8'hEE, 8'h9C};
                        e.c = 8'hF1;
                        m_copies++;
                        if (m_copies == REP) begin
                            sent = 1'b1;
                            m_active = 1'b0;
                        end else begin
                            m_next_ok = cyc + RGAP;
                            m_deadline = m_next_ok + MAXW - 1;
                        end
                    end else if (cyc == m_deadline) begin
                        to = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (m_ready && v) begin
                m_active = 1'b1;
                m_seq = m_seq + 4'd1;
                m_code = code;
                m_copies = 0;
                m_next_ok = cyc + 1;
                m_deadline = cyc + MAXW;
                m_acc_cyc = cyc;
            end
            m_ready = !m_active;
            e.flags = {m_ready, m_active, sent, to};
        end
    endtask

    task automatic step(input logic rst, input logic [63:0] d, input logic [7:0] c,
                        input logic v, input logic [1:0] code);
        exp_t e;
        @(negedge tx_clk);
        tx_rst = rst;
        xgmii_txd_in = d;
        xgmii_txc_in = c;
        pause_req_valid = v;
        pause_req_code = code;
        model_step(rst, d, c, v, code, e);
        sb_q.push_back(e);
        @(posedge tx_clk);
        #1;
        e = sb_q.pop_front();
        check("txd", xgmii_txd_out, e.d);
        check("txc", {56'd0, xgmii_txc_out}, {56'd0, e.c});
        check("flags_rdy_busy_sent_to",
              {60'd0, pause_req_ready, pause_busy, pause_sent, pause_timeout}, {60'd0, e.flags});
        if (xgmii_txc_out == 8'hF1) begin
            pause_cnt++;
            last_seq = xgmii_txd_out[27:24];
            last_code = xgmii_txd_out[17:16];
            pause_cyc.push_back(cyc);
            seqs.push_back(xgmii_txd_out[27:24]);
        end
        if (pause_sent) sent_cnt++;
        if (pause_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, IDLE_W, 8'hFF, 1'b0, 2'b00);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, IDLE_W, 8'hFF, 1'b0, 2'b00);
        idle_steps(1);
    endtask

    task automatic clear_obs();
        pause_cnt = 0;
        sent_cnt = 0;
        to_cnt = 0;
        pause_cyc.delete();
        seqs.delete();
    endtask

    initial begin
        int term_cyc;
        int guard;
        logic [63:0] w;

        // 1: three copies on an idle line
        do_reset(3);
        check("rst_ready_after_release", {63'd0, pause_req_ready}, 64'd1);
        clear_obs();
        step(1'b0, IDLE_W, 8'hFF, 1'b1, 2'b01);
        idle_steps(20);
        check("s1_count", pause_cnt, REP);
        check("s1_seq", last_seq, 4'd1);
        check("s1_code_lane2", last_code, 2'b01);
        check("s1_sent_pulses", sent_cnt, 1);
        if (pause_cyc.size() >= 3) begin
            check("s1_first_latency", pause_cyc[0] - m_acc_cyc, 1);
            check("s1_gap01", pause_cyc[1] - pause_cyc[0], RGAP);
            check("s1_gap12", pause_cyc[2] - pause_cyc[1], RGAP);
        end

        // 3: non-idle line (data, error, near-idle words) forces a timeout
        clear_obs();
        step(1'b0, {$urandom, $urandom}, 8'h00, 1'b1, 2'b11);
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: step(1'b0, {$urandom, $urandom}, 8'h00, 1'b0, 2'b00);
                1: step(1'b0, {8{8'hFE}}, 8'hFF, 1'b0, 2'b00);
                2: step(1'b0, IDLE_W, 8'h7F, 1'b0, 2'b00);
                default: step(1'b0, 64'h0707_0707_0807_0707, 8'hFF, 1'b0, 2'b00);
            endcase
        end
        check("s3_timeouts", to_cnt, 1);
        check("s3_no_pause", pause_cnt, 0);
        check("s3_timeout_cycle", to_cyc - m_acc_cyc, MAXW);
        check("s3_no_sent", sent_cnt, 0);
`ifdef IPG_PAUSE_STATS_EN
        check("stat_sent", stat_sent, 1);
        check("stat_timeout", stat_timeout, 1);
`endif

        // 2: request raised near the end of a 1500-byte frame
        clear_obs();
        step(1'b0, {8'hD5, {6{8'h55}}, 8'hFB}, 8'h01, 1'b0, 2'b00);
        for (int i = 0; i < 187; i++) begin
            w = {$urandom, $urandom};
            step(1'b0, w, 8'h00, (i == 180), 2'b10);
        end
        term_cyc = cyc;
        step(1'b0, {{3{8'h07}}, 8'hFD, 32'(($urandom))}, 8'hF0, 1'b0, 2'b00);
        idle_steps(20);
        check("s2_count", pause_cnt, REP);
        check("s2_sent", sent_cnt, 1);
        if (pause_cyc.size() >= 1) check("s2_first_after_term", pause_cyc[0], term_cyc + 1);

        // 4: 17 back-to-back requests with valid held high
        do_reset(2);
        clear_obs();
        guard = 0;
        while (sent_cnt < 17 && guard < 400) begin
            step(1'b0, IDLE_W, 8'hFF, 1'b1, 2'($urandom_range(0, 3)));
            guard++;
        end
        check("s4_sent_within_budget", sent_cnt, 17);
        check("s4_pause_words", pause_cnt, 17 * REP);
        for (int i = 0; i < seqs.size(); i++) begin
            check("s4_seq", seqs[i], 64'((i / REP + 1) % 16));
        end
        idle_steps(4);

        // 5: reset between copy 1 and copy 2
        do_reset(2);
        clear_obs();
        step(1'b0, IDLE_W, 8'hFF, 1'b1, 2'b10);
        guard = 0;
        while (pause_cnt < 1 && guard < 10) begin
            idle_steps(1);
            guard++;
        end
        check("s5_first_copy_seen", pause_cnt, 1);
        step(1'b1, IDLE_W, 8'hFF, 1'b0, 2'b00);
        check("s5_txd_idle_on_reset", xgmii_txd_out, IDLE_W);
        idle_steps(12);
        check("s5_no_sent", sent_cnt, 0);
        check("s5_no_more_copies", pause_cnt, 1);
        step(1'b0, IDLE_W, 8'hFF, 1'b1, 2'b11);
        idle_steps(20);
        check("s5_new_seq", last_seq, 4'd1);
        check("s5_new_sent", sent_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
